// File: rtl/ctu_clsp_pkg.sv
// CTU clock/reset sequencer shared definitions.
// Reset source indices and default latency slot.
package ctu_clsp_pkg;

  localparam int CTU_GLOB_LAT_DFLT = 3;
  localparam int CTU_RST_GRST      = 0;
  localparam int CTU_RST_DBGINIT   = 1;

  localparam int CTU_NUM_CKEN_MAX  = 16;

  // Width of a down-counter that must hold values 0..n-1.
  function automatic int ctu_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctu_clsp_rst_seq.sv
// One reset source: arm window flop plus registered
// active-low reset output released on the latency slot.
module ctu_clsp_rst_seq
  import ctu_clsp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic assert_req,
  input  logic rel_slot,
  input  logic cnt_zero,
  input  logic sync_edge,
  output logic win,
  output logic out_l
);

  logic win_nxt;
  logic out_l_nxt;

  // Window opens on a sync-edge request at cnt_zero and
  // closes at the following cnt_zero; opening wins.
  always_comb begin
    win_nxt = win;
    if (!run) begin
      win_nxt = 1'b0;
    end else if (sync_edge && cnt_zero) begin
      win_nxt = 1'b1;
    end else if (cnt_zero && win) begin
      win_nxt = 1'b0;
    end
  end

  // Assert requests beat a release landing in the same cycle.
  always_comb begin
    out_l_nxt = out_l;
    if (!run) begin
      out_l_nxt = 1'b0;
    end else if (assert_req) begin
      out_l_nxt = 1'b0;
    end else if (win && rel_slot) begin
      out_l_nxt = 1'b1;
    end
  end

  // Window and reset output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win   <= 1'b0;
      out_l <= 1'b0;
    end else begin
      win   <= win_nxt;
      out_l <= out_l_nxt;
    end
  end

endmodule

// File: rtl/ctu_clsp_gen_gif.sv
// Parametrised clock-domain global interface: LCM sync
// counter, per-source reset sequencing, staggered cken.
module ctu_clsp_gen_gif
  import ctu_clsp_pkg::*;
#(
  parameter int NUM_CKEN = 6,
  parameter int NUM_RST  = 2,
  parameter int CNT_W    = 10,
  parameter int GLOB_LAT = CTU_GLOB_LAT_DFLT,
  parameter int STAGGER  = 2
) (
  input  logic                dram_gclk,
  input  logic                io_pwron_rst_l,
  input  logic                start_clk_early_l,
  input  logic                start_clk_dg,
  input  logic                testmode_l,
  input  logic                jtag_force_cken,
  input  logic [CNT_W-1:0]    div_mult,
  input  logic [NUM_CKEN-1:0] cken_dg,
  input  logic [NUM_RST-1:0]  a_rst_dg,
  input  logic [NUM_RST-1:0]  sync_edge_dg,
  output logic [NUM_CKEN-1:0] cken,
  output logic [NUM_RST-1:0]  rst_out_l,
  output logic [NUM_RST-1:0]  arst_l,
  output logic                cken_busy
);

  localparam int STG_W = ctu_cnt_w(STAGGER);
  localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER - 1);

  logic [CNT_W-1:0]    lcm_cnt;
  logic [CNT_W-1:0]    lcm_nxt;
  logic                cnt_zero;
  logic                rel_slot;

  logic [NUM_RST-1:0]  win;

  logic                force_on;
  logic [NUM_CKEN-1:0] req;
  logic [NUM_CKEN-1:0] pending;
  logic [NUM_CKEN-1:0] first;
  logic [NUM_CKEN-1:0] cken_nxt;
  logic [STG_W-1:0]    stg_cnt;
  logic [STG_W-1:0]    stg_nxt;
  logic                busy_nxt;

  assign arst_l = {NUM_RST{io_pwron_rst_l}};

  assign cnt_zero = (lcm_cnt[CNT_W-1:1] == '0);
  assign rel_slot = (lcm_cnt == CNT_W'(GLOB_LAT));

  // Down-counter reloading from div_mult at 1/0 or on demand.
  always_comb begin
    lcm_nxt = lcm_cnt - CNT_W'(1);
    if (!start_clk_early_l || cnt_zero) begin
      lcm_nxt = div_mult;
    end
  end

  // LCM counter register.
  always_ff @(posedge dram_gclk or negedge io_pwron_rst_l) begin
    if (!io_pwron_rst_l) begin
      lcm_cnt <= '0;
    end else begin
      lcm_cnt <= lcm_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RST; i++) begin : g_rst
    ctu_clsp_rst_seq u_seq (
      .clk        (dram_gclk),
      .rst_n      (io_pwron_rst_l),
      .run        (start_clk_dg),
      .assert_req (|a_rst_dg[i:0]),
      .rel_slot   (rel_slot),
      .cnt_zero   (cnt_zero),
      .sync_edge  (sync_edge_dg[i]),
      .win        (win[i]),
      .out_l      (rst_out_l[i])
    );
  end

  // Turn-offs are immediate; turn-ons go one channel at a
  // time, lowest index first, spaced by the stagger counter.
  always_comb begin
    force_on = jtag_force_cken | ~testmode_l;
    req      = cken_dg & {NUM_CKEN{start_clk_dg}};
    pending  = req & ~cken;
    first    = pending & (~pending + NUM_CKEN'(1));
    cken_nxt = cken & req;
    stg_nxt  = stg_cnt;
    busy_nxt = (|pending) & ~force_on;
    if (force_on) begin
      cken_nxt = '1;
      stg_nxt  = '0;
    end else if (stg_cnt == '0) begin
      if (|pending) begin
        cken_nxt = cken_nxt | first;
        stg_nxt  = STG_LOAD;
      end
    end else begin
      stg_nxt = stg_cnt - STG_W'(1);
    end
  end

  // Clock-enable, stagger and busy registers.
  always_ff @(posedge dram_gclk or negedge io_pwron_rst_l) begin
    if (!io_pwron_rst_l) begin
      cken      <= '0;
      stg_cnt   <= '0;
      cken_busy <= 1'b0;
    end else begin
      cken      <= cken_nxt;
      stg_cnt   <= stg_nxt;
      cken_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ctu_clsp_gen_gif.sv
// Directed bench for ctu_clsp_gen_gif: LCM counter, reset
// sequencing and staggered cken with forcing and reset.
module tb_ctu_clsp_gen_gif;

  logic       clk;
  logic       rst_l;
  logic       early_l;
  logic       start_dg;
  logic       testmode_l;
  logic       jtag_force;
  logic [9:0] div_mult;
  logic [5:0] cken_dg;
  logic [1:0] a_rst;
  logic [1:0] sync_edge;
  logic [5:0] cken;
  logic [1:0] rst_out_l;
  logic [1:0] arst_l;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  ctu_clsp_gen_gif #(
    .NUM_CKEN (6),
    .NUM_RST  (2),
    .CNT_W    (10),
    .GLOB_LAT (3),
    .STAGGER  (4)
  ) dut (
    .dram_gclk         (clk),
    .io_pwron_rst_l    (rst_l),
    .start_clk_early_l (early_l),
    .start_clk_dg      (start_dg),
    .testmode_l        (testmode_l),
    .jtag_force_cken   (jtag_force),
    .div_mult          (div_mult),
    .cken_dg           (cken_dg),
    .a_rst_dg          (a_rst),
    .sync_edge_dg      (sync_edge),
    .cken              (cken),
    .rst_out_l         (rst_out_l),
    .arst_l            (arst_l),
    .cken_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [9:0] seq [6];
    seq = '{10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd5};

    rst_l      = 1'b0;
    early_l    = 1'b1;
    start_dg   = 1'b0;
    testmode_l = 1'b1;
    jtag_force = 1'b0;
    div_mult   = 10'd5;
    cken_dg    = '0;
    a_rst      = '0;
    sync_edge  = '0;
    step(2);
    chk("rst_cken", 32'(cken), 32'h0);
    chk("rst_out", 32'(rst_out_l), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_arst", 32'(arst_l), 32'h0);
    chk("rst_lcm", 32'(dut.lcm_cnt), 32'h0);
    rst_l = 1'b1;
    #1;
    chk("arst_rel", 32'(arst_l), 32'h3);

    // LCM counter with div_mult=5
    early_l = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      early_l = 1'b1;
      chk($sformatf("lcm_%0d", i), 32'(dut.lcm_cnt),
          32'(seq[i]));
      chk($sformatf("czero_%0d", i), 32'(dut.cnt_zero),
          (seq[i] == 10'd1) ? 32'h1 : 32'h0);
    end

    // Reset release and grst assert, div_mult=8
    div_mult = 10'd8;
    start_dg = 1'b1;
    early_l  = 1'b0;
    step(1);
    early_l = 1'b1;
    chk("lcm_8", 32'(dut.lcm_cnt), 32'd8);
    step(7);
    chk("czero_arm", 32'(dut.cnt_zero), 32'h1);
    sync_edge = 2'b11;
    step(1);
    sync_edge = 2'b00;
    step(5);
    chk("lcm_lat", 32'(dut.lcm_cnt), 32'd3);
    chk("pre_rel", 32'(rst_out_l), 32'h0);
    step(1);
    chk("rel_both", 32'(rst_out_l), 32'h3);
    a_rst = 2'b01;
    step(1);
    a_rst = 2'b00;
    chk("grst_all", 32'(rst_out_l), 32'h0);
    sync_edge = 2'b01;
    step(1);
    sync_edge = 2'b00;
    step(5);
    chk("pre_rel0", 32'(rst_out_l), 32'h0);
    step(1);
    chk("rel_src0", 32'(rst_out_l), 32'h1);

    // dbginit assert collides with its own release
    step(1);
    sync_edge = 2'b11;
    step(1);
    sync_edge = 2'b00;
    step(5);
    chk("lcm_lat2", 32'(dut.lcm_cnt), 32'd3);
    a_rst = 2'b10;
    step(1);
    a_rst = 2'b00;
    chk("assert_wins", 32'(rst_out_l), 32'h1);

    // Staggered turn-on, STAGGER=4
    cken_dg = 6'h3F;
    step(1);
    chk("stg_ch0", 32'(cken), 32'h01);
    chk("busy_on", 32'(busy), 32'h1);
    for (int k = 1; k < 6; k++) begin
      step(3);
      chk($sformatf("stg_hold%0d", k), 32'(cken),
          32'((1 << k) - 1));
      step(1);
      chk($sformatf("stg_ch%0d", k), 32'(cken),
          32'((1 << (k + 1)) - 1));
    end
    chk("busy_last", 32'(busy), 32'h1);
    step(1);
    chk("busy_off", 32'(busy), 32'h0);
    chk("all_on", 32'(cken), 32'h3F);

    // Forcing via testmode and jtag
    cken_dg = 6'h00;
    step(1);
    chk("fall_all", 32'(cken), 32'h0);
    testmode_l = 1'b0;
    step(1);
    chk("tm_force", 32'(cken), 32'h3F);
    testmode_l = 1'b1;
    step(1);
    chk("tm_rel", 32'(cken), 32'h0);
    jtag_force = 1'b1;
    step(1);
    chk("jtag_force", 32'(cken), 32'h3F);
    jtag_force = 1'b0;
    cken_dg    = 6'h3F;
    step(1);
    chk("jtag_rel", 32'(cken), 32'h3F);
    chk("jtag_busy", 32'(busy), 32'h0);

    // Power-on reset mid-stagger
    cken_dg = 6'h00;
    step(1);
    cken_dg = 6'h3F;
    step(1);
    chk("re_ch0", 32'(cken), 32'h01);
    step(8);
    chk("mid_3on", 32'(cken), 32'h07);
    step(1);
    rst_l = 1'b0;
    #1;
    chk("por_cken", 32'(cken), 32'h0);
    chk("por_out", 32'(rst_out_l), 32'h0);
    chk("por_busy", 32'(busy), 32'h0);
    chk("por_arst", 32'(arst_l), 32'h0);
    step(2);
    rst_l = 1'b1;
    step(1);
    chk("restart_ch0", 32'(cken), 32'h01);
    step(3);
    chk("restart_hold", 32'(cken), 32'h01);
    step(1);
    chk("restart_ch1", 32'(cken), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
